// File: rtl/arm_pkg.sv
// arm_pkg: shared widths, data-memory base address and memory-stage FSM states.
package arm_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam logic [31:0] DATA_BASE = 32'd1024;
  typedef enum logic {IDLE, BUSY} mem_state_t;
endpackage

// File: rtl/sram_wait_ctrl.sv
// sram_wait_ctrl: IDLE/BUSY wait-state sequencer that holds an SRAM access for WAIT_CYCLES cycles.
module sram_wait_ctrl
  import arm_pkg::*;
#(
  parameter int WAIT_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done
);
  mem_state_t state, state_n;
  logic [3:0] cnt, cnt_n;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end

  always_comb begin
    busy = state == BUSY;
    done = busy && cnt == 4'(WAIT_CYCLES - 1);
    state_n = busy ? (done ? IDLE : BUSY) : (start ? BUSY : IDLE);
    cnt_n = (busy && !done) ? cnt + 4'd1 : 4'd0;
  end
endmodule

// File: rtl/mem_stage_unit.sv
// mem_stage_unit: EXE->MEM pipeline register plus multi-cycle SRAM access with upstream freeze.
// Define MEM_ADDR_CHECK_EN to reject out-of-range data addresses and raise a sticky mem_fault.
module mem_stage_unit
  import arm_pkg::*;
#(
  parameter int WAIT_CYCLES = 5,
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_r_en,
  input  logic                  exe_mem_w_en,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic [DATA_W-1:0]     exe_alu_res,
  input  logic [DATA_W-1:0]     exe_val_rm,
  output logic [REG_ADDR_W-1:0] MEM_Dest,
  output logic                  MEM_WB_en,
  output logic [DATA_W-1:0]     MEM_val,
  output logic                  mem_r_en_q,
  output logic [DATA_W-1:0]     mem_rd_data,
  output logic                  freeze,
  output logic                  wb_valid,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  input  logic [DATA_W-1:0]     sram_rdata,
  output logic                  mem_fault
);
  logic mem_w_en_q, busy, done, start, fault_in;
  logic [DATA_W-1:0] val_rm_q, off_q;

`ifdef MEM_ADDR_CHECK_EN
  logic [DATA_W-1:0] off_in;
  assign off_in = exe_alu_res - DATA_BASE;
  assign fault_in = (exe_mem_r_en | exe_mem_w_en) &
                    ((exe_alu_res < DATA_BASE) | ((off_in >> (ADDR_W + 2)) != '0));
`else
  assign fault_in = 1'b0;
`endif

  assign start = ~busy & (exe_mem_r_en | exe_mem_w_en) & ~fault_in;

  sram_wait_ctrl #(.WAIT_CYCLES(WAIT_CYCLES)) u_ctrl (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      MEM_Dest <= '0;
      MEM_WB_en <= 1'b0;
      MEM_val <= '0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      val_rm_q <= '0;
      mem_rd_data <= '0;
      mem_fault <= 1'b0;
    end else begin
      if (!busy) begin
        MEM_Dest <= exe_dest;
        MEM_WB_en <= exe_wb_en;
        MEM_val <= exe_alu_res;
        mem_r_en_q <= exe_mem_r_en;
        mem_w_en_q <= exe_mem_w_en;
        val_rm_q <= exe_val_rm;
        mem_fault <= mem_fault | fault_in;
        if (fault_in && exe_mem_r_en && !exe_mem_w_en) mem_rd_data <= '0;
      end
      // a write wins when decode sets both flags, so no load data is taken
      if (done && mem_r_en_q && !mem_w_en_q) mem_rd_data <= sram_rdata;
    end

  assign off_q = MEM_val - DATA_BASE;
  assign sram_addr = ADDR_W'(off_q >> 2);
  assign freeze = busy;
  assign wb_valid = ~busy;
  assign sram_en = busy;
  assign sram_we = busy & mem_w_en_q;
  assign sram_wdata = val_rm_q;
endmodule

// File: tb/tb_mem_stage_unit.sv
// tb_mem_stage_unit: directed self-checking bench for mem_stage_unit (WAIT_CYCLES=5 and 1).
module tb_mem_stage_unit;
  logic clk = 0, rst = 1;
  logic exe_wb_en = 0, exe_mem_r_en = 0, exe_mem_w_en = 0;
  logic [3:0] exe_dest = 0;
  logic [31:0] exe_alu_res = 0, exe_val_rm = 0, sram_rdata = 0;
  logic [3:0] MEM_Dest;
  logic MEM_WB_en, mem_r_en_q, freeze, wb_valid, sram_en, sram_we, mem_fault;
  logic [31:0] MEM_val, mem_rd_data, sram_wdata;
  logic [15:0] sram_addr;
  logic [3:0] w1_dest;
  logic w1_wb_en, w1_r_en_q, w1_freeze, w1_wb_valid, w1_sram_en, w1_sram_we, w1_fault;
  logic [31:0] w1_val, w1_rd_data, w1_wdata;
  logic [15:0] w1_addr;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mem_stage_unit #(.WAIT_CYCLES(5), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .exe_mem_w_en(exe_mem_w_en), .exe_dest(exe_dest), .exe_alu_res(exe_alu_res),
    .exe_val_rm(exe_val_rm), .MEM_Dest(MEM_Dest), .MEM_WB_en(MEM_WB_en), .MEM_val(MEM_val),
    .mem_r_en_q(mem_r_en_q), .mem_rd_data(mem_rd_data), .freeze(freeze), .wb_valid(wb_valid),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .mem_fault(mem_fault)
  );

  mem_stage_unit #(.WAIT_CYCLES(1), .ADDR_W(16)) u_w1 (
    .clk(clk), .rst(rst), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .exe_mem_w_en(exe_mem_w_en), .exe_dest(exe_dest), .exe_alu_res(exe_alu_res),
    .exe_val_rm(exe_val_rm), .MEM_Dest(w1_dest), .MEM_WB_en(w1_wb_en), .MEM_val(w1_val),
    .mem_r_en_q(w1_r_en_q), .mem_rd_data(w1_rd_data), .freeze(w1_freeze), .wb_valid(w1_wb_valid),
    .sram_en(w1_sram_en), .sram_we(w1_sram_we), .sram_addr(w1_addr), .sram_wdata(w1_wdata),
    .sram_rdata(sram_rdata), .mem_fault(w1_fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wb, input logic r, input logic w, input logic [3:0] d,
                       input logic [31:0] a, input logic [31:0] rm);
    exe_wb_en = wb; exe_mem_r_en = r; exe_mem_w_en = w;
    exe_dest = d; exe_alu_res = a; exe_val_rm = rm;
  endtask

  task automatic test_reset();
    rst = 1;
    #1;
    checks++;
    if ({MEM_Dest, MEM_WB_en, MEM_val, mem_r_en_q, mem_rd_data, freeze, sram_en, sram_we, mem_fault} !== '0) begin
      errors++;
      $display("FAIL reset_outputs dest=%0d wb=%b val=%h rd=%h frz=%b en=%b we=%b flt=%b expected all 0",
               MEM_Dest, MEM_WB_en, MEM_val, mem_rd_data, freeze, sram_en, sram_we, mem_fault);
    end
    checks++;
    if (wb_valid !== 1'b1) begin errors++; $display("FAIL reset_wb_valid got %b expected 1", wb_valid); end
    step();
    rst = 0;
  endtask

  task automatic test_alu();
    drive(1, 0, 0, 4'd3, 32'd42, 32'd0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (MEM_Dest !== 4'd3 || MEM_WB_en !== 1'b1 || MEM_val !== 32'd42 || freeze !== 1'b0) begin
      errors++;
      $display("FAIL alu_capture dest=%0d wb=%b val=%0d frz=%b expected 3 1 42 0", MEM_Dest, MEM_WB_en, MEM_val, freeze);
    end
    step();
    checks++;
    if (freeze !== 1'b0) begin errors++; $display("FAIL alu_no_freeze got %b expected 0", freeze); end
  endtask

  task automatic test_store();
    drive(0, 0, 1, 4'd5, 32'd1028, 32'hDEADBEEF);
    step();
    drive(1, 0, 0, 4'd7, 32'd99, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (freeze !== 1'b1 || sram_we !== 1'b1 || sram_en !== 1'b1 || sram_addr !== 16'd1 ||
          sram_wdata !== 32'hDEADBEEF || MEM_val !== 32'd1028 || MEM_Dest !== 4'd5) begin
        errors++;
        $display("FAIL store_cycle%0d frz=%b we=%b en=%b addr=%0d wd=%h val=%0d dest=%0d expected 1 1 1 1 deadbeef 1028 5",
                 i, freeze, sram_we, sram_en, sram_addr, sram_wdata, MEM_val, MEM_Dest);
      end
      step();
    end
    checks++;
    if (freeze !== 1'b0 || sram_en !== 1'b0 || sram_we !== 1'b0) begin
      errors++;
      $display("FAIL store_end frz=%b en=%b we=%b expected 0 0 0", freeze, sram_en, sram_we);
    end
    step();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (MEM_val !== 32'd99 || MEM_Dest !== 4'd7 || freeze !== 1'b0) begin
      errors++;
      $display("FAIL store_next_capture val=%0d dest=%0d frz=%b expected 99 7 0", MEM_val, MEM_Dest, freeze);
    end
  endtask

  task automatic test_load();
    sram_rdata = 32'hDEADBEEF;
    drive(1, 1, 0, 4'd2, 32'd1028, 32'd0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wb_valid !== 1'b0 || sram_we !== 1'b0 || mem_rd_data !== 32'd0 || sram_addr !== 16'd1) begin
        errors++;
        $display("FAIL load_cycle%0d wbv=%b we=%b rd=%h addr=%0d expected 0 0 0 1", i, wb_valid, sram_we, mem_rd_data, sram_addr);
      end
      step();
    end
    checks++;
    if (mem_rd_data !== 32'hDEADBEEF || freeze !== 1'b0 || mem_r_en_q !== 1'b1) begin
      errors++;
      $display("FAIL load_done rd=%h frz=%b ren=%b expected deadbeef 0 1", mem_rd_data, freeze, mem_r_en_q);
    end
  endtask

  task automatic test_back_to_back();
    int fcnt = 0, cap = -1;
    sram_rdata = 32'h11111111;
    drive(1, 1, 0, 4'd1, 32'd1032, 32'd0);
    step();
    drive(1, 1, 0, 4'd4, 32'd1036, 32'd0);
    for (int k = 0; k < 15; k++) begin
      if (freeze === 1'b1) fcnt++;
      if (k == 5) begin
        checks++;
        if (mem_rd_data !== 32'h11111111) begin
          errors++;
          $display("FAIL b2b_first_data got %h expected 11111111", mem_rd_data);
        end
        sram_rdata = 32'h22222222;
      end
      step();
      if (cap < 0 && MEM_val === 32'd1036) begin
        cap = k + 1;
        drive(0, 0, 0, 0, 0, 0);
      end
    end
    checks++;
    if (cap !== 6) begin errors++; $display("FAIL b2b_capture_edge got %0d expected 6", cap); end
    checks++;
    if (fcnt !== 10) begin errors++; $display("FAIL b2b_freeze_cycles got %0d expected 10", fcnt); end
    checks++;
    if (mem_rd_data !== 32'h22222222) begin errors++; $display("FAIL b2b_second_data got %h expected 22222222", mem_rd_data); end
  endtask

  task automatic test_addr_check();
    drive(1, 1, 0, 4'd6, 32'd512, 32'd0);
    step();
    drive(0, 0, 0, 0, 0, 0);
`ifdef MEM_ADDR_CHECK_EN
    checks++;
    if (freeze !== 1'b0 || sram_en !== 1'b0 || mem_rd_data !== 32'd0 || mem_fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_load frz=%b en=%b rd=%h flt=%b expected 0 0 0 1", freeze, sram_en, mem_rd_data, mem_fault);
    end
    step();
    step();
    checks++;
    if (mem_fault !== 1'b1) begin errors++; $display("FAIL fault_sticky got %b expected 1", mem_fault); end
`else
    checks++;
    if (freeze !== 1'b1 || sram_addr !== 16'hFF80 || mem_fault !== 1'b0) begin
      errors++;
      $display("FAIL wrap_load frz=%b addr=%h flt=%b expected 1 ff80 0", freeze, sram_addr, mem_fault);
    end
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (freeze !== 1'b0) begin errors++; $display("FAIL wrap_end got %b expected 0", freeze); end
`endif
  endtask

  task automatic test_reset_mid();
    int fcnt = 0;
    drive(1, 0, 1, 4'd9, 32'd1040, 32'hCAFEF00D);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1;
    #1;
    checks++;
    if (freeze !== 1'b0 || sram_en !== 1'b0 || sram_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_strobes frz=%b en=%b we=%b expected 0 0 0", freeze, sram_en, sram_we);
    end
    checks++;
    if ({MEM_Dest, MEM_WB_en, MEM_val, mem_r_en_q, mem_rd_data, sram_wdata, mem_fault} !== '0) begin
      errors++;
      $display("FAIL rst_mid_regs dest=%0d wb=%b val=%h rd=%h wd=%h flt=%b expected all 0",
               MEM_Dest, MEM_WB_en, MEM_val, mem_rd_data, sram_wdata, mem_fault);
    end
    step();
    rst = 0;
    checks++;
    if (freeze !== 1'b0) begin errors++; $display("FAIL rst_no_retry got %b expected 0", freeze); end
    drive(0, 0, 1, 4'd0, 32'd1028, 32'h00000001);
    step();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (sram_we !== 1'b1 || sram_addr !== 16'd1 || sram_wdata !== 32'd1) begin
      errors++;
      $display("FAIL rst_next_store we=%b addr=%0d wd=%h expected 1 1 1", sram_we, sram_addr, sram_wdata);
    end
    for (int i = 0; i < 8; i++) begin
      if (freeze === 1'b1) fcnt++;
      step();
    end
    checks++;
    if (fcnt !== 5) begin errors++; $display("FAIL rst_next_freeze got %0d expected 5", fcnt); end
  endtask

  task automatic test_wait1();
    drive(0, 0, 1, 4'd1, 32'd1032, 32'hA5A5A5A5);
    step();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (w1_freeze !== 1'b1 || w1_sram_we !== 1'b1 || w1_addr !== 16'd2) begin
      errors++;
      $display("FAIL w1_busy frz=%b we=%b addr=%0d expected 1 1 2", w1_freeze, w1_sram_we, w1_addr);
    end
    step();
    checks++;
    if (w1_freeze !== 1'b0 || w1_wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL w1_release frz=%b wbv=%b expected 0 1", w1_freeze, w1_wb_valid);
    end
    for (int i = 0; i < 5; i++) step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_back_to_back();
    test_addr_check();
    test_reset_mid();
    test_wait1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
